// File: rtl/ddr_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rx_pkg
// Description : Shared types and sizing helpers for the dual-rate receive
//               deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_rx_pkg;

  // Alignment state: IDLE discards pairs, FILL accumulates a word.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Output word width: two beats per pair, RATIO pairs per word.
  function automatic int calc_word_w(input int data_w, input int ratio);
    return 2 * ratio * data_w;
  endfunction

  // Slot counter width; a single-slot word still needs a one-bit counter.
  function automatic int calc_cnt_w(input int ratio);
    if (ratio <= 2) begin
      return 1;
    end
    return $clog2(ratio);
  endfunction

endpackage : ddr_rx_pkg
`default_nettype wire

// File: rtl/ddr_rx_outreg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rx_outreg
// Description : Single-entry valid/ready holding register. A load that
//               arrives while the entry is occupied and not being consumed is
//               dropped and reported with a one-cycle drop pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rx_outreg #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         accept;

  // Next-state: accept when empty or draining this cycle, else drop the load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    accept  = load_i & (~valid_q | ready_i);
    drop_o  = load_i & valid_q & ~ready_i;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register; data keeps its last value after consumption.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : ddr_rx_outreg
`default_nettype wire

// File: rtl/ddr_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rx_deser
// Description : Packs beat pairs from the dual-edge capture stage into wide
//               single-rate words, aligned to a SYNC marker, and presents
//               them on a valid/ready interface with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rx_deser
  import ddr_rx_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter int   RATIO  = 2,
  localparam int  WORD_W = calc_word_w(DATA_W, RATIO)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic [DATA_W-1:0] D_FIRST,
  input  logic [DATA_W-1:0] D_SECOND,
  input  logic              SYNC,
  input  logic              CLR_OVF,
  output logic [WORD_W-1:0] WORD_O,
  output logic              VALID_O,
  input  logic              READY_I,
  output logic              ALIGNED_O,
  output logic              OVF_O
);

  localparam int             CNT_W     = calc_cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_d;
  logic              ovf_q;
  logic              ovf_d;

  logic              wr_en;
  logic [CNT_W-1:0]  wr_slot;
  logic              word_done;
  logic              drop;

  // Slot selection, accumulator write and word-completion detection.
  // SYNC always forces slot 0, which silently discards any partial word.
  // The completed word is taken from acc_d so the final pair lands in the
  // output register on the same edge it is sampled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wr_en     = 1'b0;
    wr_slot   = '0;
    word_done = 1'b0;

    if (CE) begin
      if (SYNC) begin
        wr_en   = 1'b1;
        wr_slot = '0;
        state_d = FILL;
      end else if (state_q == FILL) begin
        wr_en   = 1'b1;
        wr_slot = cnt_q;
      end
    end

    if (wr_en) begin
      for (int s = 0; s < RATIO; s++) begin
        if (wr_slot == CNT_W'(s)) begin
          acc_d[2*s*DATA_W +: 2*DATA_W] = {D_SECOND, D_FIRST};
        end
      end
      if (wr_slot == LAST_SLOT) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = wr_slot + CNT_W'(1);
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // State, slot counter, accumulator and overflow registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  ddr_rx_outreg #(
    .W (WORD_W)
  ) u_outreg (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (word_done),
    .data_i  (acc_d),
    .ready_i (READY_I),
    .valid_o (VALID_O),
    .data_o  (WORD_O),
    .drop_o  (drop)
  );

  assign ALIGNED_O = (state_q == FILL);
  assign OVF_O     = ovf_q;

endmodule : ddr_rx_deser
`default_nettype wire

// File: tb/tb_ddr_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_rx_deser
// Description : Self-checking bench for ddr_rx_deser (DATA_W=8, RATIO=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_rx_deser;

  localparam int DATA_W = 8;
  localparam int RATIO  = 2;
  localparam int WORD_W = 2 * RATIO * DATA_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CE = 1'b0;
  logic [DATA_W-1:0] D_FIRST = '0;
  logic [DATA_W-1:0] D_SECOND = '0;
  logic              SYNC = 1'b0;
  logic              CLR_OVF = 1'b0;
  logic              READY_I = 1'b0;
  logic [WORD_W-1:0] WORD_O;
  logic              VALID_O;
  logic              ALIGNED_O;
  logic              OVF_O;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: beats collected since the last SYNC, plus output entry.
  logic              m_aligned;
  logic [DATA_W-1:0] m_beats[$];
  logic [WORD_W-1:0] m_word;
  logic              m_valid;
  logic              m_ovf;

  ddr_rx_deser #(
    .DATA_W (DATA_W),
    .RATIO  (RATIO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .D_FIRST   (D_FIRST),
    .D_SECOND  (D_SECOND),
    .SYNC      (SYNC),
    .CLR_OVF   (CLR_OVF),
    .WORD_O    (WORD_O),
    .VALID_O   (VALID_O),
    .READY_I   (READY_I),
    .ALIGNED_O (ALIGNED_O),
    .OVF_O     (OVF_O)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_aligned = 1'b0;
    m_beats.delete();
    m_word  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic ce, input logic [DATA_W-1:0] f,
                            input logic [DATA_W-1:0] s, input logic sync,
                            input logic ready, input logic clr);
    logic              done;
    logic              dropped;
    logic [WORD_W-1:0] w;
    done    = 1'b0;
    dropped = 1'b0;
    w       = '0;
    if (ce) begin
      if (sync) begin
        m_beats.delete();
        m_aligned = 1'b1;
      end
      if (m_aligned) begin
        m_beats.push_back(f);
        m_beats.push_back(s);
        if (m_beats.size() == 2 * RATIO) begin
          for (int i = 0; i < 2 * RATIO; i++) w[i*DATA_W +: DATA_W] = m_beats[i];
          m_beats.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!m_valid || ready) begin
        m_word  = w;
        m_valid = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1ns.
  task automatic cycle(input logic ce, input logic [DATA_W-1:0] f,
                       input logic [DATA_W-1:0] s, input logic sync,
                       input logic ready, input logic clr);
    CE = ce; D_FIRST = f; D_SECOND = s; SYNC = sync; READY_I = ready; CLR_OVF = clr;
    @(posedge CLK);
    model_step(ce, f, s, sync, ready, clr);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2 RST = 1'b0;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    n_checks++;
    if (VALID_O !== 1'b0 || ALIGNED_O !== 1'b0 || WORD_O !== '0 || OVF_O !== 1'b0)
      $display("FAIL reset_vals: got v=%b a=%b w=%h o=%b required all zero", VALID_O, ALIGNED_O, WORD_O, OVF_O);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (VALID_O !== 1'b0 || ALIGNED_O !== 1'b0 || WORD_O !== '0)
        $display("FAIL idle_no_sync[%0d]: got v=%b a=%b w=%h required 0/0/0", i, VALID_O, ALIGNED_O, WORD_O);
      else n_pass++;
    end
  endtask

  task automatic test_basic_pack();
    cycle(1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b0 || ALIGNED_O !== 1'b1)
      $display("FAIL basic_first: got v=%b a=%b required v=0 a=1", VALID_O, ALIGNED_O);
    else n_pass++;
    cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b1 || WORD_O !== 32'h44332211)
      $display("FAIL basic_word: got v=%b w=%h required v=1 w=44332211", VALID_O, WORD_O);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b0 || WORD_O !== 32'h44332211)
      $display("FAIL basic_drain: got v=%b w=%h required v=0 w=44332211", VALID_O, WORD_O);
    else n_pass++;
  endtask

  task automatic test_ce_gaps();
    cycle(1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
      n_checks++;
      if (VALID_O !== 1'b0 || ALIGNED_O !== 1'b1)
        $display("FAIL gap_hold[%0d]: got v=%b a=%b required v=0 a=1", i, VALID_O, ALIGNED_O);
      else n_pass++;
    end
    cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b1 || WORD_O !== 32'h44332211)
      $display("FAIL gap_word: got v=%b w=%h required v=1 w=44332211", VALID_O, WORD_O);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_realign();
    cycle(1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 8'hBB, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b0)
      $display("FAIL realign_no_word: got v=%b required v=0", VALID_O);
    else n_pass++;
    cycle(1'b1, 8'hCC, 8'hDD, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b1 || WORD_O !== 32'hDDCCBBAA || OVF_O !== 1'b0)
      $display("FAIL realign_word: got v=%b w=%h o=%b required v=1 w=ddccbbaa o=0", VALID_O, WORD_O, OVF_O);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    cycle(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b1 || WORD_O !== 32'h04030201 || OVF_O !== 1'b0)
      $display("FAIL ovf_first: got v=%b w=%h o=%b required v=1 w=04030201 o=0", VALID_O, WORD_O, OVF_O);
    else n_pass++;
    cycle(1'b1, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 8'h08, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b1 || WORD_O !== 32'h04030201 || OVF_O !== 1'b1)
      $display("FAIL ovf_set: got v=%b w=%h o=%b required v=1 w=04030201 o=1", VALID_O, WORD_O, OVF_O);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (OVF_O !== 1'b0 || VALID_O !== 1'b1)
      $display("FAIL ovf_clear: got o=%b v=%b required o=0 v=1", OVF_O, VALID_O);
    else n_pass++;
    // Drop coinciding with a clear: the set must win.
    cycle(1'b1, 8'h09, 8'h0A, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h0B, 8'h0C, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (OVF_O !== 1'b1 || WORD_O !== 32'h04030201)
      $display("FAIL ovf_set_wins: got o=%b w=%h required o=1 w=04030201", OVF_O, WORD_O);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (VALID_O !== 1'b0 || OVF_O !== 1'b0)
      $display("FAIL ovf_drain: got v=%b o=%b required v=0 o=0", VALID_O, OVF_O);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 8'h88, 1'b1, 1'b0, 1'b0);
    #2 RST = 1'b0;
    CE = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (VALID_O !== 1'b0 || ALIGNED_O !== 1'b0 || WORD_O !== '0 || OVF_O !== 1'b0)
      $display("FAIL async_reset: got v=%b a=%b w=%h o=%b required all zero", VALID_O, ALIGNED_O, WORD_O, OVF_O);
    else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b1;
    cycle(1'b1, 8'h99, 8'hAA, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hBB, 8'hCC, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b0 || ALIGNED_O !== 1'b0)
      $display("FAIL post_reset_unaligned: got v=%b a=%b required v=0 a=0", VALID_O, ALIGNED_O);
    else n_pass++;
    cycle(1'b1, 8'hDE, 8'hAD, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'hBE, 8'hEF, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (VALID_O !== 1'b1 || WORD_O !== 32'hEFBEADDE)
      $display("FAIL post_reset_word: got v=%b w=%h required v=1 w=efbeadde", VALID_O, WORD_O);
    else n_pass++;
  endtask

  task automatic test_random();
    logic ce, sync, ready, clr;
    for (int i = 0; i < 400; i++) begin
      ce    = ($urandom_range(0, 3) != 0);
      sync  = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 4) < 3);
      clr   = ($urandom_range(0, 19) == 0);
      cycle(ce, 8'($urandom), 8'($urandom), sync, ready, clr);
      n_checks++;
      if (VALID_O !== m_valid)
        $display("FAIL rand_valid[%0d]: got %b required %b", i, VALID_O, m_valid);
      else n_pass++;
      n_checks++;
      if (WORD_O !== m_word)
        $display("FAIL rand_word[%0d]: got %h required %h", i, WORD_O, m_word);
      else n_pass++;
      n_checks++;
      if (ALIGNED_O !== m_aligned)
        $display("FAIL rand_aligned[%0d]: got %b required %b", i, ALIGNED_O, m_aligned);
      else n_pass++;
      n_checks++;
      if (OVF_O !== m_ovf)
        $display("FAIL rand_ovf[%0d]: got %b required %b", i, OVF_O, m_ovf);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_pack();
    test_ce_gaps();
    test_realign();
    test_overflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ddr_rx_deser
`default_nettype wire
